// File: rtl/apu_frame_counter.sv
// APU frame sequencer: turns the CPU-cycle enable into quarter/half-frame
// clock-enable pulses and the frame IRQ flag, with delayed $4017 restarts.
module apu_frame_counter #(
  parameter int unsigned STEP1       = 7457,
  parameter int unsigned STEP2       = 14913,
  parameter int unsigned STEP3       = 22371,
  parameter int unsigned STEP4       = 29829,
  parameter int unsigned STEP5       = 37281,
  parameter int unsigned WRITE_DELAY = 3
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       cpu_clk_en,
  input  logic       reg_wr,
  input  logic [1:0] reg_wr_data,
  input  logic       status_rd,
  output logic       quarter_frame_en,
  output logic       half_frame_en,
  output logic       frame_irq
);

  localparam int unsigned DLY_W = (WRITE_DELAY < 2) ? 1 : $clog2(WRITE_DELAY + 1);

  localparam logic [15:0]      S1       = 16'(STEP1);
  localparam logic [15:0]      S2       = 16'(STEP2);
  localparam logic [15:0]      S3       = 16'(STEP3);
  localparam logic [15:0]      S4       = 16'(STEP4);
  localparam logic [15:0]      S5       = 16'(STEP5);
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(WRITE_DELAY);
  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

  typedef enum logic {
    MODE_4STEP = 1'b0,
    MODE_5STEP = 1'b1
  } mode_e;

  logic [15:0]      cyc_cnt_q, cyc_cnt_d;
  mode_e            mode_q, mode_d;
  mode_e            staged_mode_q, staged_mode_d;
  logic             irq_inhibit_q, irq_inhibit_d;
  logic             frame_irq_q, frame_irq_d;
  logic             quarter_q, quarter_d;
  logic             half_q, half_d;
  logic             restart_pend_q, restart_pend_d;
  logic [DLY_W-1:0] delay_q, delay_d;

  logic [15:0]      last_step_s;
  logic             restart_fire_s;
  logic             irq_set_s;
  logic             irq_clr_s;

  // Next-state: restart landing, step decode, $4017 staging and IRQ flag.
  always_comb begin
    cyc_cnt_d      = cyc_cnt_q;
    mode_d         = mode_q;
    staged_mode_d  = staged_mode_q;
    irq_inhibit_d  = irq_inhibit_q;
    restart_pend_d = restart_pend_q;
    delay_d        = delay_q;
    quarter_d      = 1'b0;
    half_d         = 1'b0;
    irq_set_s      = 1'b0;
    last_step_s    = (mode_q == MODE_5STEP) ? S5 : S4;
    // A write in the same cycle re-arms instead of letting the old restart land.
    restart_fire_s = cpu_clk_en && restart_pend_q && !reg_wr && (delay_q == DLY_ONE);

    if (restart_fire_s) begin
      cyc_cnt_d      = 16'd0;
      mode_d         = staged_mode_q;
      restart_pend_d = 1'b0;
      if (staged_mode_q == MODE_5STEP) begin
        quarter_d = 1'b1;
        half_d    = 1'b1;
      end else begin
        quarter_d = 1'b0;
        half_d    = 1'b0;
      end
    end else if (cpu_clk_en) begin
      case (cyc_cnt_q)
        S1, S3: quarter_d = 1'b1;
        S2: begin
          quarter_d = 1'b1;
          half_d    = 1'b1;
        end
        S4: begin
          if (mode_q == MODE_4STEP) begin
            quarter_d = 1'b1;
            half_d    = 1'b1;
            irq_set_s = ~irq_inhibit_q;
          end else begin
            quarter_d = 1'b0;
          end
        end
        S5: begin
          if (mode_q == MODE_5STEP) begin
            quarter_d = 1'b1;
            half_d    = 1'b1;
          end else begin
            quarter_d = 1'b0;
          end
        end
        default: quarter_d = 1'b0;
      endcase
      cyc_cnt_d = (cyc_cnt_q == last_step_s) ? 16'd0 : cyc_cnt_q + 16'd1;
      if (restart_pend_q && !reg_wr) begin
        delay_d = delay_q - DLY_ONE;
      end else begin
        delay_d = delay_q;
      end
    end else begin
      cyc_cnt_d = cyc_cnt_q;
    end

    if (reg_wr) begin
      irq_inhibit_d  = reg_wr_data[0];
      staged_mode_d  = mode_e'(reg_wr_data[1]);
      restart_pend_d = 1'b1;
      delay_d        = DLY_LOAD;
    end else begin
      irq_inhibit_d = irq_inhibit_q;
    end

    irq_clr_s = status_rd | (reg_wr & reg_wr_data[0]);
    if (irq_set_s) begin
      frame_irq_d = 1'b1;
    end else if (irq_clr_s) begin
      frame_irq_d = 1'b0;
    end else begin
      frame_irq_d = frame_irq_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cyc_cnt_q      <= 16'd0;
      mode_q         <= MODE_4STEP;
      staged_mode_q  <= MODE_4STEP;
      irq_inhibit_q  <= 1'b0;
      frame_irq_q    <= 1'b0;
      quarter_q      <= 1'b0;
      half_q         <= 1'b0;
      restart_pend_q <= 1'b0;
      delay_q        <= '0;
    end else begin
      cyc_cnt_q      <= cyc_cnt_d;
      mode_q         <= mode_d;
      staged_mode_q  <= staged_mode_d;
      irq_inhibit_q  <= irq_inhibit_d;
      frame_irq_q    <= frame_irq_d;
      quarter_q      <= quarter_d;
      half_q         <= half_d;
      restart_pend_q <= restart_pend_d;
      delay_q        <= delay_d;
    end
  end

  assign quarter_frame_en = quarter_q;
  assign half_frame_en    = half_q;
  assign frame_irq        = frame_irq_q;

endmodule

// File: tb/tb_apu_frame_counter.sv
// Bench for apu_frame_counter: a full-size instance driven by directed steps and
// a short-period instance driven randomly, both checked against a reference model.
module tb_apu_frame_counter;

  localparam int B1 = 7457, B2 = 14913, B3 = 22371, B4 = 29829, B5 = 37281, BD = 3;
  localparam int F1 = 11, F2 = 23, F3 = 34, F4 = 46, F5 = 57, FD = 2;

  logic clk, rst_l;
  logic b_en, b_wr, b_rd, b_q, b_h, b_irq;
  logic [1:0] b_wd;
  logic f_en, f_wr, f_rd, f_q, f_h, f_irq;
  logic [1:0] f_wd;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    int pos;
    int wait_n;
    bit five;
    bit inh;
    bit irq;
    bit smode;
    bit q;
    bit h;
  } ref_t;

  ref_t mb, mf;

  apu_frame_counter u_big (
    .clk(clk), .rst_l(rst_l), .cpu_clk_en(b_en), .reg_wr(b_wr), .reg_wr_data(b_wd),
    .status_rd(b_rd), .quarter_frame_en(b_q), .half_frame_en(b_h), .frame_irq(b_irq)
  );

  apu_frame_counter #(
    .STEP1(F1), .STEP2(F2), .STEP3(F3), .STEP4(F4), .STEP5(F5), .WRITE_DELAY(FD)
  ) u_fast (
    .clk(clk), .rst_l(rst_l), .cpu_clk_en(f_en), .reg_wr(f_wr), .reg_wr_data(f_wd),
    .status_rd(f_rd), .quarter_frame_en(f_q), .half_frame_en(f_h), .frame_irq(f_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame sequencer rules: position within the frame, pending restart countdown,
  // and what the pulses/IRQ should be one clk after this cycle.
  function automatic ref_t ref_next(ref_t s, bit en, bit wr, bit [1:0] wd, bit rd,
                                    int s1, int s2, int s3, int s4, int s5, int wdel);
    ref_t n = s;
    bit set_irq = 1'b0;
    int last = s.five ? s5 : s4;
    n.q = 1'b0;
    n.h = 1'b0;
    if (en && s.wait_n == 1 && !wr) begin
      n.pos = 0;
      n.five = s.smode;
      n.wait_n = 0;
      n.q = s.smode;
      n.h = s.smode;
    end else if (en) begin
      if (s.pos == s1 || s.pos == s3) n.q = 1'b1;
      if (s.pos == s2) begin n.q = 1'b1; n.h = 1'b1; end
      if (s.pos == s4 && !s.five) begin n.q = 1'b1; n.h = 1'b1; set_irq = !s.inh; end
      if (s.pos == s5 && s.five) begin n.q = 1'b1; n.h = 1'b1; end
      n.pos = (s.pos == last) ? 0 : s.pos + 1;
      if (s.wait_n > 0 && !wr) n.wait_n = s.wait_n - 1;
    end
    if (wr) begin
      n.inh = wd[0];
      n.smode = wd[1];
      n.wait_n = wdel;
    end
    if (set_irq) n.irq = 1'b1;
    else if (rd || (wr && wd[0])) n.irq = 1'b0;
    return n;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clk: advance both models at the edge, compare at the falling edge,
  // then drop one-shot strobes and draw fresh random inputs for the fast DUT.
  task automatic tick();
    @(posedge clk);
    if (!rst_l) begin
      mb = '0;
      mf = '0;
    end else begin
      mb = ref_next(mb, b_en, b_wr, b_wd, b_rd, B1, B2, B3, B4, B5, BD);
      mf = ref_next(mf, f_en, f_wr, f_wd, f_rd, F1, F2, F3, F4, F5, FD);
    end
    @(negedge clk);
    chk("big_quarter", b_q, mb.q);
    chk("big_half", b_h, mb.h);
    chk("big_irq", b_irq, mb.irq);
    chk("fast_quarter", f_q, mf.q);
    chk("fast_half", f_h, mf.h);
    chk("fast_irq", f_irq, mf.irq);
    b_wr = 1'b0;
    b_rd = 1'b0;
    b_wd = 2'b00;
    f_en = ($urandom_range(0, 3) != 0);
    f_wr = ($urandom_range(0, 149) == 0);
    f_wd = 2'($urandom_range(0, 3));
    f_rd = ($urandom_range(0, 59) == 0);
  endtask

  initial begin
    int first_q, nq, nh;
    logic irq_any;
    int hq[$];

    rst_l = 1'b0;
    b_en = 1'b0; b_wr = 1'b0; b_wd = 2'b00; b_rd = 1'b0;
    f_en = 1'b0; f_wr = 1'b0; f_wd = 2'b00; f_rd = 1'b0;
    mb = '0;
    mf = '0;
    repeat (3) tick();
    chk("reset_quarter", b_q, 1'b0);
    chk("reset_half", b_h, 1'b0);
    chk("reset_irq", b_irq, 1'b0);

    // 4-step frame from reset; status read lands on the IRQ-setting clk.
    rst_l = 1'b1;
    b_en = 1'b1;
    first_q = 0; nq = 0; nh = 0;
    for (int i = 1; i <= B4 + 1; i++) begin
      if (i == B4 + 1) b_rd = 1'b1;
      tick();
      if (b_q) begin
        nq++;
        if (first_q == 0) first_q = i;
      end
      if (b_h) nh++;
    end
    chk_int("f1_first_quarter_tick", first_q, B1 + 1);
    chk_int("f1_quarter_count", nq, 4);
    chk_int("f1_half_count", nh, 2);
    chk("f1_step4_quarter", b_q, 1'b1);
    chk("f1_step4_half", b_h, 1'b1);
    chk("irq_set_beats_read", b_irq, 1'b1);

    // Inhibit write clears the pending IRQ; 5-step restart lands 3 cpu cycles later.
    b_wr = 1'b1; b_wd = 2'b11;
    tick();
    chk("inhibit_write_clears_irq", b_irq, 1'b0);
    tick();
    chk("restart_wait1", b_q, 1'b0);
    tick();
    chk("restart_wait2", b_q, 1'b0);
    tick();
    chk("restart_quarter", b_q, 1'b1);
    chk("restart_half", b_h, 1'b1);

    // Write at cpu 1000, rewrite at 1001: restart must wait until 1004.
    repeat (1000) tick();
    b_wr = 1'b1; b_wd = 2'b11;
    tick();
    b_wr = 1'b1; b_wd = 2'b11;
    tick();
    tick();
    tick();
    chk("rewrite_not_at_1003", b_q, 1'b0);
    tick();
    chk("rewrite_restart_quarter", b_q, 1'b1);
    chk("rewrite_restart_half", b_h, 1'b1);

    // Full 5-step frame; a write rides on its final step to leave a restart pending.
    nq = 0;
    irq_any = 1'b0;
    for (int i = 1; i <= B5 + 1; i++) begin
      if (i == B5 + 1) begin
        b_wr = 1'b1;
        b_wd = 2'b00;
      end
      tick();
      if (b_q) nq++;
      if (b_h) hq.push_back(i);
      irq_any = irq_any | b_irq;
    end
    chk_int("f5_quarter_count", nq, 4);
    chk_int("f5_half_count", hq.size(), 2);
    chk_int("f5_half_first_tick", (hq.size() > 0) ? hq[0] : -1, B2 + 1);
    chk_int("f5_half_last_tick", (hq.size() > 1) ? hq[1] : -1, B5 + 1);
    chk("f5_never_irq", irq_any, 1'b0);
    chk("f5_last_quarter", b_q, 1'b1);

    // Asynchronous reset mid-pulse with a restart pending.
    #2;
    rst_l = 1'b0;
    #1;
    chk("async_reset_quarter", b_q, 1'b0);
    chk("async_reset_half", b_h, 1'b0);
    chk("async_reset_irq", b_irq, 1'b0);
    chk("async_reset_fast_quarter", f_q, 1'b0);
    tick();
    tick();
    rst_l = 1'b1;
    first_q = 0;
    for (int i = 1; i <= B1 + 500 && first_q == 0; i++) begin
      tick();
      if (b_q) first_q = i;
    end
    chk_int("post_reset_first_quarter", first_q, B1 + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
